// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and write-port priority resolve for the register file
package regfile_pkg;

  localparam int unsigned REG_ZERO  = 0;
  localparam int          MAX_PORTS = 32;

  // Index of the highest set hit bit (highest-numbered enabled port wins), -1 when none.
  function automatic int last_hit(input logic [MAX_PORTS-1:0] hit);
    last_hit = -1;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (hit[p]) last_hit = p;
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits set on issue, cleared on writeback
// Read-port lookups see the post-edge pending state, matching the data bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_pending,
  output logic              any_pending
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [NRD-1:0]   rd_pending_q, rd_pending_d;

  // Set is applied after clears so a same-edge issue keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) pend_d[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO)))) begin
      pend_d[iss_addr] = 1'b1;
    end
    rd_pending_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_pending_d[i] = pend_d[rd_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= '0;
      rd_pending_q <= '0;
    end else begin
      pend_q       <= pend_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign rd_pending  = rd_pending_q;
  assign any_pending = |pend_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-first registered reads and pending scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_pending,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 any_pending
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [NRD*WIDTH-1:0] rd_data_q, rd_data_d;

  // mem_d is the post-edge array; reads index it directly to get the write-first bypass.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      logic [MAX_PORTS-1:0] hit;
      int                   win;
      hit = '0;
      for (int p = 0; p < NWR; p++) begin
        hit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r));
      end
      win      = last_hit(hit);
      mem_d[r] = mem_q[r];
      if (win >= 0) mem_d[r] = wr_data[win*WIDTH +: WIDTH];
      if ((ZERO_REG != 0) && (r == REG_ZERO)) mem_d[r] = '0;
    end
    rd_data_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data_d[i*WIDTH +: WIDTH] = mem_d[rd_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .rd_addr     (rd_addr),
    .rd_pending  (rd_pending),
    .any_pending (any_pending)
  );

endmodule
